// File: rtl/sirv_asyncrst_regvec_ctl.sv
// Parametrised control/status register vector: byte-strobed atomic software
// writes, sticky hardware set, lock-until-reset, and change/error pulses.
module sirv_asyncrst_regvec_ctl #(
  parameter int unsigned   DW       = 32,
  parameter logic [DW-1:0] RST_VAL  = {DW{1'b0}},
  parameter int unsigned   SBW      = (DW + 7) / 8,
  parameter bit            LOCKABLE = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [1:0]     wr_mode,
  input  logic [DW-1:0]  wr_data,
  input  logic [SBW-1:0] wr_strb,
  input  logic [DW-1:0]  hw_set,
  input  logic           lock_req,
  output logic [DW-1:0]  q,
  output logic           q_chg,
  output logic           locked,
  output logic           wr_err
);

  localparam logic [1:0] MODE_WRITE  = 2'b00;
  localparam logic [1:0] MODE_SET    = 2'b01;
  localparam logic [1:0] MODE_CLEAR  = 2'b10;
  localparam logic [1:0] MODE_TOGGLE = 2'b11;

  logic [DW-1:0] bit_en_s;
  logic [DW-1:0] op_s;
  logic [DW-1:0] sw_s;
  logic [DW-1:0] q_nxt_s;
  logic          wr_ok_s;
  logic          lock_nxt_s;

  logic [DW-1:0] q_r;
  logic          locked_r;
  logic          q_chg_r;
  logic          wr_err_r;

  // Expand byte strobes to a per-bit enable; the top strobe covers any partial byte.
  genvar g;
  generate
    for (g = 0; g < DW; g++) begin : g_strb
      assign bit_en_s[g] = wr_strb[g / 8];
    end
  endgenerate

  // Atomic-mode operand computed against the current register value.
  always_comb begin
    op_s = q_r;
    case (wr_mode)
      MODE_WRITE:  op_s = wr_data;
      MODE_SET:    op_s = q_r | wr_data;
      MODE_CLEAR:  op_s = q_r & ~wr_data;
      MODE_TOGGLE: op_s = q_r ^ wr_data;
      default:     op_s = q_r;
    endcase
  end

  assign wr_ok_s = wr_en & ~locked_r;

  // Merge the operand into strobed bits only; a rejected write leaves q untouched.
  always_comb begin
    sw_s = q_r;
    if (wr_ok_s) begin
      sw_s = (op_s & bit_en_s) | (q_r & ~bit_en_s);
    end else begin
      sw_s = q_r;
    end
  end

  // Hardware set wins over any same-cycle software clear and ignores the lock.
  assign q_nxt_s    = sw_s | hw_set;
  assign lock_nxt_s = LOCKABLE ? (locked_r | lock_req) : 1'b0;

  // Register state and the registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r      <= RST_VAL;
      locked_r <= 1'b0;
      q_chg_r  <= 1'b0;
      wr_err_r <= 1'b0;
    end else begin
      q_r      <= q_nxt_s;
      locked_r <= lock_nxt_s;
      q_chg_r  <= (q_nxt_s != q_r);
      wr_err_r <= wr_en & locked_r;
    end
  end

  assign q      = q_r;
  assign locked = locked_r;
  assign q_chg  = q_chg_r;
  assign wr_err = wr_err_r;

endmodule

// File: tb/tb_sirv_asyncrst_regvec_ctl.sv
// Bench for sirv_asyncrst_regvec_ctl: a 32-bit lockable instance and a 12-bit
// non-lockable instance, checked against a per-bit behavioural model.
module tb_sirv_asyncrst_regvec_ctl;

  localparam logic [31:0] RST32 = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        wr_en = 1'b0;
  logic [1:0]  wr_mode = 2'b00;
  logic [31:0] wr_data = 32'h0;
  logic [3:0]  wr_strb = 4'h0;
  logic [31:0] hw_set = 32'h0;
  logic        lock_req = 1'b0;
  logic [31:0] q;
  logic        q_chg, locked, wr_err;

  logic        s_wr_en = 1'b0;
  logic [1:0]  s_wr_mode = 2'b00;
  logic [11:0] s_wr_data = 12'h0;
  logic [1:0]  s_wr_strb = 2'b00;
  logic [11:0] s_hw_set = 12'h0;
  logic        s_lock_req = 1'b0;
  logic [11:0] s_q;
  logic        s_q_chg, s_locked, s_wr_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] m_q, s_mq;
  logic        m_locked, m_chg, m_err, s_mchg;

  sirv_asyncrst_regvec_ctl #(.DW(32), .RST_VAL(RST32), .LOCKABLE(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_mode(wr_mode), .wr_data(wr_data),
    .wr_strb(wr_strb), .hw_set(hw_set), .lock_req(lock_req), .q(q), .q_chg(q_chg),
    .locked(locked), .wr_err(wr_err)
  );

  sirv_asyncrst_regvec_ctl #(.DW(12), .LOCKABLE(1'b0)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .wr_en(s_wr_en), .wr_mode(s_wr_mode), .wr_data(s_wr_data),
    .wr_strb(s_wr_strb), .hw_set(s_hw_set), .lock_req(s_lock_req), .q(s_q), .q_chg(s_q_chg),
    .locked(s_locked), .wr_err(s_wr_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural next value: per-bit rules, then sticky hardware set.
  function automatic logic [63:0] model_next(input logic [63:0] cur, input logic en,
      input logic [1:0] mode, input logic [63:0] data, input logic [7:0] strb,
      input logic [63:0] hw, input logic lk, input int dw);
    logic [63:0] r;
    r = cur;
    for (int b = 0; b < dw; b++) begin
      if (en && !lk && strb[b / 8]) begin
        case (mode)
          2'd0:    r[b] = data[b];
          2'd1:    r[b] = cur[b] | data[b];
          2'd2:    r[b] = cur[b] & ~data[b];
          default: r[b] = cur[b] ^ data[b];
        endcase
      end
      r[b] = r[b] | hw[b];
    end
    return r;
  endfunction

  task automatic check_all();
    check_eq("q",        {32'h0, q},        m_q);
    check_eq("locked",   {63'h0, locked},   {63'h0, m_locked});
    check_eq("q_chg",    {63'h0, q_chg},    {63'h0, m_chg});
    check_eq("wr_err",   {63'h0, wr_err},   {63'h0, m_err});
    check_eq("s_q",      {52'h0, s_q},      s_mq);
    check_eq("s_locked", {63'h0, s_locked}, 64'h0);
    check_eq("s_q_chg",  {63'h0, s_q_chg},  {63'h0, s_mchg});
    check_eq("s_wr_err", {63'h0, s_wr_err}, 64'h0);
  endtask

  task automatic model_reset();
    m_q = {32'h0, RST32};
    m_locked = 1'b0; m_chg = 1'b0; m_err = 1'b0;
    s_mq = 64'h0; s_mchg = 1'b0;
  endtask

  // One clock: predict from the held inputs, take the edge, compare 1 ns later.
  task automatic step();
    logic [63:0] nq, ns;
    nq = model_next(m_q, wr_en, wr_mode, {32'h0, wr_data}, {4'h0, wr_strb},
                    {32'h0, hw_set}, m_locked, 32);
    ns = model_next(s_mq, s_wr_en, s_wr_mode, {52'h0, s_wr_data}, {6'h0, s_wr_strb},
                    {52'h0, s_hw_set}, 1'b0, 12);
    @(posedge clk);
    m_err    = wr_en & m_locked;
    m_chg    = (nq != m_q);
    m_q      = nq;
    m_locked = m_locked | lock_req;
    s_mchg   = (ns != s_mq);
    s_mq     = ns;
    #1;
    check_all();
  endtask

  task automatic set_big(input logic en, input logic [1:0] mode, input logic [31:0] data,
      input logic [3:0] strb, input logic [31:0] hw, input logic lk);
    wr_en = en; wr_mode = mode; wr_data = data; wr_strb = strb; hw_set = hw; lock_req = lk;
  endtask

  task automatic set_small(input logic en, input logic [1:0] mode, input logic [11:0] data,
      input logic [1:0] strb, input logic [11:0] hw, input logic lk);
    s_wr_en = en; s_wr_mode = mode; s_wr_data = data; s_wr_strb = strb; s_hw_set = hw;
    s_lock_req = lk;
  endtask

  task automatic rand_cycles(input int n, input bit allow_lock);
    for (int i = 0; i < n; i++) begin
      set_big($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom, 4'($urandom),
              $urandom & $urandom & $urandom & $urandom,
              allow_lock && ($urandom_range(0, 31) == 0));
      set_small($urandom_range(0, 1), 2'($urandom_range(0, 3)), 12'($urandom),
                2'($urandom), 12'($urandom & $urandom & $urandom), $urandom_range(0, 1));
      step();
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    step();
    check_eq("idle_q", {32'h0, q}, {32'h0, RST32});
    check_eq("idle_chg", {63'h0, q_chg}, 64'h0);

    // Clear, then a strobed write; the 12-bit instance exercises its partial top byte.
    set_big(1'b1, 2'b00, 32'h0, 4'hF, 32'h0, 1'b0);
    set_small(1'b1, 2'b00, 12'hFFF, 2'b10, 12'h0, 1'b0);
    step();
    check_eq("s_part_q", {52'h0, s_q}, 64'hF00);
    set_big(1'b1, 2'b00, 32'hDEADBEEF, 4'b0101, 32'h0, 1'b0);
    set_small(1'b0, 2'b00, 12'h0, 2'b00, 12'h0, 1'b1);
    step();
    check_eq("wr_q", {32'h0, q}, 64'h00AD00EF);
    check_eq("wr_chg", {63'h0, q_chg}, 64'h1);
    check_eq("s_nolock", {63'h0, s_locked}, 64'h0);
    set_small(1'b1, 2'b00, 12'h0AB, 2'b11, 12'h0, 1'b0);
    step();
    check_eq("rewr_chg", {63'h0, q_chg}, 64'h0);
    check_eq("s_after_lockreq_q", {52'h0, s_q}, 64'h0AB);
    check_eq("s_after_lockreq_err", {63'h0, s_wr_err}, 64'h0);
    set_small(1'b0, 2'b00, 12'h0, 2'b00, 12'h0, 1'b0);

    // Atomic modes.
    set_big(1'b1, 2'b00, 32'h0000FFFF, 4'hF, 32'h0, 1'b0); step();
    set_big(1'b1, 2'b01, 32'h00FF0000, 4'hF, 32'h0, 1'b0); step();
    check_eq("set_q", {32'h0, q}, 64'h00FFFFFF);
    set_big(1'b1, 2'b10, 32'h000000F0, 4'hF, 32'h0, 1'b0); step();
    check_eq("clr_q", {32'h0, q}, 64'h00FFFF0F);
    set_big(1'b1, 2'b11, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0); step();
    check_eq("tog_q", {32'h0, q}, 64'hFF0000F0);
    set_big(1'b1, 2'b00, 32'h12345678, 4'h0, 32'h0, 1'b0); step();
    check_eq("strb0_chg", {63'h0, q_chg}, 64'h0);
    set_big(1'b1, 2'b11, 32'h0, 4'hF, 32'h0, 1'b0); step();
    check_eq("tog0_chg", {63'h0, q_chg}, 64'h0);

    // Hardware set beats a same-cycle clear.
    set_big(1'b1, 2'b00, 32'h000000FF, 4'hF, 32'h0, 1'b0); step();
    set_big(1'b1, 2'b10, 32'h000000FF, 4'hF, 32'h00000001, 1'b0); step();
    check_eq("hwprio_q", {32'h0, q}, 64'h00000001);

    rand_cycles(200, 1'b0);

    // Lock sequence.
    set_big(1'b1, 2'b00, 32'h12345678, 4'hF, 32'h0, 1'b1); step();
    check_eq("lock_q", {32'h0, q}, 64'h12345678);
    check_eq("lock_locked", {63'h0, locked}, 64'h1);
    set_big(1'b1, 2'b00, 32'h0, 4'hF, 32'h0, 1'b0); step();
    check_eq("lkwr_q", {32'h0, q}, 64'h12345678);
    check_eq("lkwr_err", {63'h0, wr_err}, 64'h1);
    check_eq("lkwr_chg", {63'h0, q_chg}, 64'h0);
    set_big(1'b0, 2'b00, 32'h0, 4'h0, 32'h80000000, 1'b0); step();
    check_eq("lkhw_q", {32'h0, q}, 64'h92345678);
    check_eq("lkhw_err", {63'h0, wr_err}, 64'h0);

    rand_cycles(50, 1'b1);

    // Asynchronous reset while a write is pending: write discarded, lock cleared.
    set_big(1'b1, 2'b00, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    set_big(1'b0, 2'b00, 32'h0, 4'h0, 32'h0, 1'b0);
    set_small(1'b0, 2'b00, 12'h0, 2'b00, 12'h0, 1'b0);
    rst_n = 1'b1;
    step();
    check_eq("post_rst_q", {32'h0, q}, {32'h0, RST32});

    rand_cycles(300, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sirv_asyncrst_regvec_ctl.md
Name: sirv_asyncrst_regvec_ctl

Overview:
- Parametrised control/status register vector with asynchronous reset. Successor to the fixed-width per-bit async-reset register vectors in the peripheral set.
- Adds:
  - configurable width and reset value
  - byte strobes
  - atomic write modes (write/set/clear/toggle)
  - sticky hardware-set inputs
  - a lock-until-reset mechanism
  - change and error pulses
- Sits between a peripheral's bus-side register decode and its always-on/AON control logic.

Parameters:
- DW, 32, register width in bits, 1..64; the top strobe covers any partial byte.
- RST_VAL, {DW{1'b0}}, value loaded into q while rst_n is low.
- SBW, (DW+7)/8, derived strobe width; must not be overridden.
- LOCKABLE, 1; when 0, lock_req is ignored and locked is tied 0.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  asynchronous reset, active-low.
- wr_en  in  1  software write request, one-cycle qualifier.
- wr_mode  in  2  00=write, 01=set, 10=clear, 11=toggle.
- wr_data  in  DW  write operand.
- wr_strb  in  SBW  byte enables; bit i covers q[8i+7:8i].
- hw_set  in  DW  hardware sticky-set bits, sampled every cycle.
- lock_req  in  1  request to lock software writes until the next reset.
- q  out  DW  current register value.
- q_chg  out  1  one-cycle pulse: q changed value at the last edge.
- locked  out  1  software writes are blocked.
- wr_err  out  1  one-cycle pulse: a write was rejected because of the lock.

Behaviour:
- Clocking and reset:
  - Clock is clk; reset is asynchronous, active-low on rst_n.
  - While rst_n=0: q=RST_VAL, locked=0, q_chg=0, wr_err=0.
  - Reset assertion mid-write discards the write.
  - Deassertion is synchronised externally; the first active edge after deassertion behaves normally.
- Latency: all updates are registered; q reflects a write/hw_set at the clk edge that samples it, i.e. visible the next cycle. There is no combinational path from inputs to q.
- Software operand per bit b, with byte n=b/8, when wr_en=1, locked=0 and wr_strb[n]=1:
  - write: sw[b]=wr_data[b]
  - set: sw[b]=q[b] | wr_data[b]
  - clear: sw[b]=q[b] & ~wr_data[b]
  - toggle: sw[b]=q[b] ^ wr_data[b]
  - Otherwise sw[b]=q[b]. Unstrobed bytes always hold.
- Next value: q_nxt = sw | hw_set.
  - hw_set has priority over a same-cycle software clear/write-0 of that bit; the bit ends at 1.
  - hw_set is applied regardless of lock.
- Lock:
  - If LOCKABLE=1 and lock_req=1 at an edge, locked becomes 1 and stays 1 until rst_n is asserted.
  - A write in the same cycle as lock_req is still performed; the lock takes effect from the following cycle.
  - lock_req while already locked has no effect.
- wr_err:
  - Registered. Equals 1 the cycle after an edge where wr_en=1 and locked=1, regardless of strobes or mode.
  - Otherwise 0. Back-to-back rejected writes give back-to-back pulses.
- q_chg:
  - Registered. Equals 1 in the cycle after any edge where q_nxt != q, aligned with the new q value.
  - No pulse for a write that yields an identical value: e.g. set of already-set bits, wr_strb=0, or a locked write.
- Write-mode edge values:
  - wr_en=1 with wr_strb=0: no update, no q_chg, no error.
  - Toggle with wr_data=0 gives no change.
- Widths:
  - For DW not a multiple of 8, wr_strb[SBW-1] covers bits [DW-1:8*(SBW-1)] only.
  - Out-of-range strobe bits do not exist.

Test Plan:
- Reset with DW=32, RST_VAL=32'hA5A5_0000: hold rst_n=0 -> q=A5A50000, locked=0, q_chg=0, wr_err=0. Then release and apply no stimulus -> q unchanged, q_chg stays 0.
- Write mode from q=0: wr_en=1, mode=00, wr_data=DEADBEEF, strb=0101 -> next cycle q=00AD00EF, q_chg=1 for exactly one cycle. Repeat the same write -> q_chg=0.
- Atomic modes from q=0000FFFF, strb=1111:
  - set 00FF0000 -> 00FFFFFF
  - clear 000000F0 -> 00FFFF0F
  - toggle FFFFFFFF -> FF0000F0
- hw_set priority from q=000000FF: clear 000000FF with hw_set=00000001 in the same cycle -> q=00000001.
- Lock, in order:
  - Write 12345678 together with lock_req=1 -> q=12345678, locked=1 next cycle.
  - Write 0 -> q holds, wr_err=1 for one cycle, q_chg=0.
  - hw_set=80000000 -> q=92345678.
  - Pulse rst_n low -> locked=0, q=RST_VAL.
- Partial width and LOCKABLE=0, with DW=12, SBW=2:
  - strb=10, write FFF -> q=F00.
  - lock_req=1 with LOCKABLE=0 -> locked stays 0, and a later write succeeds with no wr_err.
